ahb_lite_master_bridge: RTL

//  Sits directly downstream of the processor core's data-access port.

---
 rtl/ahb_lite_master_bridge_pkg.sv | 58 +++++
 rtl/ahb_lite_master_bridge_if.sv | 43 ++++
 rtl/ahb_lane_steer.sv | 38 +++
 rtl/ahb_lite_master_bridge.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_bridge_pkg.sv
// AHB-Lite master bridge: shared encodings, FSM states and size helpers.
// ST_ERR exists only when AHB_BRIDGE_ERR_EN is defined.
package ahb_lite_master_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
`ifdef AHB_BRIDGE_ERR_EN
        , ST_ERR
`endif
    } state_t;

    // Core size 2'b11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (sz == SZ_HALF): bad = lo[0];
            (sz == SZ_WORD): bad = |lo;
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] align_addr(input logic [31:0] a,
                                               input logic [1:0]  sz);
        logic [31:0] r;
        r = a;
        unique case (1'b1)
            (sz == SZ_HALF): r = {a[31:1], 1'b0};
            (sz == SZ_WORD): r = {a[31:2], 2'b00};
            default:         r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_lite_master_bridge_if.sv
// AHB-Lite master bridge: core request port and AHB-Lite bus signals.
// master = bridge view, slave = core/bus environment view.
interface ahb_lite_master_bridge_if;

    logic        core_rd_en;
    logic        core_wr_en;
    logic [31:0] core_addr;
    logic [31:0] core_wr_data;
    logic [1:0]  core_size;
    logic [31:0] core_rd_data;
    logic        core_rd_vld;
    logic        core_busy;
    logic        core_err;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  core_rd_en, core_wr_en, core_addr, core_wr_data, core_size,
        input  hrdata, hready, hresp,
        output core_rd_data, core_rd_vld, core_busy, core_err,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        output hwdata
    );

    modport slave (
        output core_rd_en, core_wr_en, core_addr, core_wr_data, core_size,
        output hrdata, hready, hresp,
        input  core_rd_data, core_rd_vld, core_busy, core_err,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        input  hwdata
    );

endinterface

// File: rtl/ahb_lane_steer.sv
// AHB-Lite master bridge: byte/halfword lane steering.
// Write data replicated across lanes; read data extracted and zero-extended.
module ahb_lane_steer
    import ahb_lite_master_bridge_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_bus,
    output logic [31:0] rd_data
);

    // Replicate the right-aligned write datum into every lane it may hit.
    always_comb begin
        wr_lanes = wr_data;
        unique case (1'b1)
            (wr_size == SZ_BYTE): wr_lanes = {4{wr_data[7:0]}};
            (wr_size == SZ_HALF): wr_lanes = {2{wr_data[15:0]}};
            default:              wr_lanes = wr_data;
        endcase
    end

    // Pull the addressed lane down to bit 0 and zero-extend.
    always_comb begin
        rd_data = rd_bus;
        unique case (1'b1)
            (rd_size == SZ_BYTE):
                rd_data = (rd_bus >> {rd_addr_lo, 3'b000}) & 32'h0000_00ff;
            (rd_size == SZ_HALF):
                rd_data = (rd_bus >> {rd_addr_lo[1], 4'b0000}) & 32'h0000_ffff;
            default:
                rd_data = rd_bus;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite master bridge: core rd/wr handshake to AHB-Lite SINGLE transfers.
// AHB_BRIDGE_ERR_EN enables hresp handling and misaligned-request rejection.
module ahb_lite_master_bridge
    import ahb_lite_master_bridge_pkg::*;
#(
    parameter logic [3:0]  HPROT_VAL = 4'b0011,
    parameter logic [31:0] HADDR_RST = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ahb_lite_master_bridge_if.master  bus
);

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_pend_q, rd_pend_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic        err_q, err_d;
    logic        busy_q;

    logic        req;
    logic [1:0]  req_sz;
    logic        req_bad;
    logic [31:0] req_addr;
    logic [31:0] wr_lanes;
    logic [31:0] rd_lane;

    assign req    = bus.core_rd_en | bus.core_wr_en;
    assign req_sz = norm_size(bus.core_size);

`ifdef AHB_BRIDGE_ERR_EN
    assign req_bad  = misaligned(req_sz, bus.core_addr[1:0]);
    assign req_addr = bus.core_addr;
`else
    logic unused_hresp;
    assign unused_hresp = bus.hresp;
    assign req_bad  = 1'b0;
    assign req_addr = align_addr(bus.core_addr, req_sz);
`endif

    ahb_lane_steer u_steer (
        .wr_size    (req_sz),
        .wr_data    (bus.core_wr_data),
        .wr_lanes   (wr_lanes),
        .rd_size    (hsize_q[1:0]),
        .rd_addr_lo (haddr_q[1:0]),
        .rd_bus     (bus.hrdata),
        .rd_data    (rd_lane)
    );

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        hwdata_d  = hwdata_q;
        wdata_d   = wdata_q;
        rd_pend_d = rd_pend_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Write wins when both strobes are high.
                    rd_pend_d = ~bus.core_wr_en;
                    if (req_bad) begin
`ifdef AHB_BRIDGE_ERR_EN
                        state_d = ST_ERR;
`endif
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = bus.core_wr_en;
                        hsize_d  = {1'b0, req_sz};
                        wdata_d  = wr_lanes;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.hready) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) hwdata_d = wdata_q;
                end
            end
            ST_DATA: begin
                if (bus.hready) begin
                    state_d  = ST_IDLE;
                    haddr_d  = HADDR_RST;
                    hwrite_d = 1'b0;
                    hsize_d  = HSIZE_BYTE;
                    rd_vld_d = rd_pend_q;
                    if (rd_pend_q) rd_data_d = rd_lane;
`ifdef AHB_BRIDGE_ERR_EN
                    if (bus.hresp == HRESP_ERROR) begin
                        err_d = 1'b1;
                        if (rd_pend_q) rd_data_d = 32'h0;
                    end
`endif
                end
            end
`ifdef AHB_BRIDGE_ERR_EN
            ST_ERR: begin
                state_d  = ST_IDLE;
                err_d    = 1'b1;
                rd_vld_d = rd_pend_q;
                if (rd_pend_q) rd_data_d = 32'h0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transfer at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            haddr_q   <= HADDR_RST;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hsize_q   <= HSIZE_BYTE;
            hwdata_q  <= 32'h0;
            wdata_q   <= 32'h0;
            rd_pend_q <= 1'b0;
            rd_data_q <= 32'h0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hwdata_q  <= hwdata_d;
            wdata_q   <= wdata_d;
            rd_pend_q <= rd_pend_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            err_q     <= err_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.haddr        = haddr_q;
    assign bus.htrans       = htrans_q;
    assign bus.hwrite       = hwrite_q;
    assign bus.hsize        = hsize_q;
    assign bus.hburst       = HBURST_SINGLE;
    assign bus.hprot        = HPROT_VAL;
    assign bus.hmastlock    = 1'b0;
    assign bus.hwdata       = hwdata_q;
    assign bus.core_rd_data = rd_data_q;
    assign bus.core_rd_vld  = rd_vld_q;
    assign bus.core_busy    = busy_q;
    assign bus.core_err     = err_q;

endmodule
